// File: rtl/initiator_port.sv
`default_nettype none
// ============================================================================
// initiator_port: serial-bus front end for a bus initiator.
// Serializes a 16-bit address and 8-bit write data LSB first, collects serial
// read data and the target ACK, and returns a completion or timeout pulse.
// Revision: 1.0
// ============================================================================
module initiator_port #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] init_addr,
    input  logic [7:0]  init_wdata,
    input  logic        init_rw,
    output logic        init_ready,
    output logic [7:0]  init_rdata,
    output logic        init_done,
    output logic        init_err,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_mode,
    output logic        bus_rw,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        bus_target_ready,
    input  logic        bus_target_ack
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_ADDR     = 3'd2,
        S_GAP_A    = 3'd3,
        S_WDATA    = 3'd4,
        S_GAP_D    = 3'd5,
        S_WAIT_ACK = 3'd6,
        S_RDATA    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ack_q, ack_d;
    logic [7:0]    rbuf_q, rbuf_d;

    logic          ready_q, ready_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          breq_q, breq_d;
    logic          dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          mode_q, mode_d;
    logic          brw_q, brw_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        ack_d   = ack_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // The ACK is remembered from ADDR onward so an early ACK is never lost.
        if ((state_q != S_IDLE) && (state_q != S_REQ) && bus_target_ack) begin
            ack_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (init_req && ready_q) begin
                    addr_d  = init_addr;
                    wdata_d = init_wdata;
                    rw_d    = init_rw;
                    ack_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_grant && bus_target_ready) begin
                    cnt_d   = 4'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = S_GAP_A;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP_A: begin
                tcnt_d  = '0;
                state_d = rw_q ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (cnt_q == 4'd7) begin
                    state_d = S_GAP_D;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP_D: begin
                tcnt_d  = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tcnt_d = tcnt_q + 1'b1;
                if (ack_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                tcnt_d = tcnt_q + 1'b1;
                // cnt_q[3] marks all 8 bits received; later bits are dropped.
                if (bus_data_in_valid && !cnt_q[3]) begin
                    rbuf_d[cnt_q[2:0]] = bus_data_in;
                    cnt_d              = cnt_q + 4'd1;
                end
                if (cnt_q[3] && ack_q) begin
                    rdata_d = rbuf_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready only after a full cycle in IDLE, so it rises the cycle after a completion.
        ready_d  = (state_q == S_IDLE) && (state_d == S_IDLE);
        breq_d   = (state_d != S_IDLE);
        brw_d    = (state_d != S_IDLE) && rw_d;
        dvalid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
        mode_d   = (state_d == S_WDATA);
        dout_d   = 1'b0;
        if (state_d == S_ADDR) begin
            dout_d = addr_d[cnt_d];
        end else if (state_d == S_WDATA) begin
            dout_d = wdata_d[cnt_d[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 16'd0;
            wdata_q  <= 8'd0;
            rw_q     <= 1'b0;
            cnt_q    <= 4'd0;
            tcnt_q   <= '0;
            ack_q    <= 1'b0;
            rbuf_q   <= 8'd0;
            ready_q  <= 1'b1;
            rdata_q  <= 8'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            breq_q   <= 1'b0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            mode_q   <= 1'b0;
            brw_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            ack_q    <= ack_d;
            rbuf_q   <= rbuf_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            breq_q   <= breq_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            mode_q   <= mode_d;
            brw_q    <= brw_d;
        end
    end

    assign init_ready         = ready_q;
    assign init_rdata         = rdata_q;
    assign init_done          = done_q;
    assign init_err           = err_q;
    assign bus_req            = breq_q;
    assign bus_data_out       = dout_q;
    assign bus_data_out_valid = dvalid_q;
    assign bus_mode           = mode_q;
    assign bus_rw             = brw_q;

endmodule
`default_nettype wire

// File: tb/tb_initiator_port.sv
`default_nettype none
// ============================================================================
// tb_initiator_port: scoreboard bench for initiator_port with a target model.
// Revision: 1.0
// ============================================================================
module tb_initiator_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic [15:0] init_addr = 16'd0;
    logic [7:0]  init_wdata = 8'd0;
    logic        init_rw = 1'b0;
    logic        init_ready;
    logic [7:0]  init_rdata;
    logic        init_done;
    logic        init_err;
    logic        bus_req;
    logic        bus_grant = 1'b0;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_rw;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_target_ready = 1'b0;
    logic        bus_target_ack = 1'b0;

    initiator_port #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata),
        .init_rw(init_rw), .init_ready(init_ready), .init_rdata(init_rdata),
        .init_done(init_done), .init_err(init_err),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_data_out(bus_data_out),
        .bus_data_out_valid(bus_data_out_valid), .bus_mode(bus_mode), .bus_rw(bus_rw),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .bus_target_ready(bus_target_ready), .bus_target_ack(bus_target_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit d;
        bit m;
        bit rw;
        int c;
    } bit_exp_t;

    typedef struct {
        bit         err;
        logic [7:0] rd;
        int         c;
    } cmp_exp_t;

    bit_exp_t   bitq[$];
    cmp_exp_t   cmpq[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] rd_model = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every serial bit and every completion is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_data_out_valid) begin
                if (bitq.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    bit_exp_t e;
                    e = bitq.pop_front();
                    chk("bit_data", bus_data_out, e.d);
                    chk("bit_mode", bus_mode, e.m);
                    chk("bit_rw", bus_rw, e.rw);
                    chk("bit_cycle", cyc, e.c);
                end
            end
            if (init_done || init_err) begin
                if (cmpq.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    cmp_exp_t c;
                    c = cmpq.pop_front();
                    chk("cmp_done", init_done, !c.err);
                    chk("cmp_err", init_err, c.err);
                    chk("cmp_rdata", init_rdata, c.rd);
                    chk("cmp_cycle", cyc, c.c);
                    chk("cmp_busreq_low", bus_req, 0);
                    chk("cmp_ready_low", init_ready, 0);
                end
            end
        end
    end

    // ackmode: 0 = no ACK, 1 = early (before end of serialization), 2 = late, 3 = during WDATA
    task automatic run_txn(input bit rw, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int gdelay, input int ackmode);
        bit vld[64];
        bit din[64];
        bit ackv[64];
        int t, lb, ca, dc, g;
        t = 0;
        while (!init_ready && t < 60) begin
            step();
            t++;
        end
        chk("ready_before_req", init_ready, 1);
        init_req = 1'b1; init_addr = a; init_wdata = wd; init_rw = rw;
        step();
        init_req = 1'b0; init_addr = 16'($urandom); init_wdata = 8'($urandom); init_rw = 1'($urandom);
        chk("ready_low_after_accept", init_ready, 0);
        chk("busreq_after_accept", bus_req, 1);
        for (int i = 0; i < gdelay; i++) begin
            chk("busreq_in_wait", bus_req, 1);
            chk("valid_low_in_wait", bus_data_out_valid, 0);
            if ($urandom_range(0, 1) == 1) begin
                bus_grant = 1'b1; bus_target_ready = 1'b0;
            end else begin
                bus_grant = 1'b0; bus_target_ready = 1'($urandom);
            end
            bus_target_ack = 1'($urandom);
            step();
        end
        bus_grant = 1'b1; bus_target_ready = 1'b1; bus_target_ack = 1'b0;
        step();
        g = cyc;
        bus_grant = 1'b0; bus_target_ready = 1'($urandom);
        chk("first_bit_valid", bus_data_out_valid, 1);

        for (int i = 0; i < 16; i++) bitq.push_back('{a[i], 1'b0, rw, g + i});
        if (rw) for (int j = 0; j < 8; j++) bitq.push_back('{wd[j], 1'b1, 1'b1, g + 17 + j});

        for (int k = 0; k < 64; k++) begin
            vld[k] = 1'($urandom); din[k] = 1'($urandom); ackv[k] = 1'b0;
        end
        lb = 0;
        if (!rw) begin
            for (int k = 17; k < 64; k++) vld[k] = 1'b0;
            t = 17;
            for (int b = 0; b < 8; b++) begin
                t += $urandom_range(0, 1);
                vld[t] = 1'b1; din[t] = rd[b]; lb = t;
                t++;
            end
            vld[t] = 1'b1; vld[t + 1] = 1'($urandom);
        end
        case (ackmode)
            1:       ca = $urandom_range(0, rw ? 25 : 16);
            2:       ca = rw ? $urandom_range(25, 30) : lb + $urandom_range(0, 2);
            3:       ca = $urandom_range(17, 24);
            default: ca = -1;
        endcase
        if (ca >= 0) ackv[ca] = 1'b1;

        if (ca < 0) dc = rw ? 46 : 37;
        else if (rw) dc = (ca + 2 > 27) ? ca + 2 : 27;
        else dc = ((lb > ca) ? lb : ca) + 2;
        if (ca >= 0 && !rw) rd_model = rd;
        cmpq.push_back('{(ca < 0), rd_model, g + dc});

        for (int k = 0; k < dc; k++) begin
            bus_data_in_valid = vld[k]; bus_data_in = din[k]; bus_target_ack = ackv[k];
            step();
        end
        bus_data_in_valid = 1'b0; bus_target_ack = 1'b0; bus_target_ready = 1'b0;
        step();
        chk("ready_after_completion", init_ready, 1);
        chk("single_pulse", init_done | init_err, 0);
    endtask

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", init_ready, 1);
        chk("rst_busreq", bus_req, 0);
        chk("rst_valid", bus_data_out_valid, 0);
        chk("rst_rdata", init_rdata, 0);
        chk("rst_done_err", {init_done, init_err, bus_mode, bus_rw, bus_data_out}, 0);
        rst_n = 1'b1;
        step();

        run_txn(1'b1, 16'h0532, 8'h9E, 8'h00, 0, 2);   // write, immediate grant
        run_txn(1'b0, 16'h0532, 8'h00, 8'h9E, 0, 2);   // read with idle gaps
        run_txn(1'b1, 16'hA5C3, 8'h3C, 8'h00, 5, 2);   // grant withheld 5 cycles
        run_txn(1'b1, 16'h1234, 8'hC1, 8'h00, 1, 3);   // ACK during WDATA
        run_txn(1'b1, 16'hFFFF, 8'hFF, 8'h00, 0, 0);   // write timeout
        run_txn(1'b0, 16'h0001, 8'h00, 8'h77, 2, 0);   // read timeout keeps rdata
        run_txn(1'b0, 16'h8000, 8'h00, 8'h41, 0, 1);   // read, ACK before data

        // Reset in the middle of the address phase.
        init_req = 1'b1; init_addr = 16'hBEEF; init_wdata = 8'h5A; init_rw = 1'b1;
        step();
        init_req = 1'b0; bus_grant = 1'b1; bus_target_ready = 1'b1;
        step();
        g = cyc;
        bus_grant = 1'b0; bus_target_ready = 1'b0;
        for (int i = 0; i < 16; i++) bitq.push_back('{init_addr[i], 1'b0, 1'b1, g + i});
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", init_ready, 1);
        chk("midrst_busreq", bus_req, 0);
        chk("midrst_valid", bus_data_out_valid, 0);
        chk("midrst_rdata", init_rdata, 0);
        chk("midrst_others", {init_done, init_err, bus_mode, bus_rw, bus_data_out}, 0);
        bitq.delete();
        cmpq.delete();
        rd_model = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        run_txn(1'b1, 16'h0532, 8'h9E, 8'h00, 0, 2);

        for (int n = 0; n < 30; n++) begin
            int am;
            am = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 2);
            run_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 4), am);
        end

        repeat (3) step();
        chk("queues_drained", bitq.size() + cmpq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
